// File: rtl/store_buffer_unit.sv
// store_buffer_unit
//   Store path between the execute stage and the data-memory write port.
//   Incoming stores are formatted into lane-positioned data and byte
//   enables, checked for alignment/legality, and queued in a DEPTH-entry
//   FIFO that drains to memory over a valid/ready handshake. Loads are
//   checked against all pending entries at word granularity.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   st_valid/st_ready          store request handshake
//   st_type                    00=SB 01=SH 10=SW 11=SD
//   st_addr, st_data           byte address and rs2 data
//   st_err_valid/st_err_addr   one-cycle pulse for misaligned/illegal stores
//   mem_valid/mem_ready        head-entry handshake toward memory
//   mem_addr/mem_wdata/mem_be  head entry: aligned address, data, byte enables
//   ld_addr/ld_conflict        load word address and pending-store match flag
//   flush                      discard all buffered entries
//   count, empty               occupancy
module store_buffer_unit #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [1:0]                st_type,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [XLEN-1:0]           st_data,
  output logic                      st_err_valid,
  output logic [ADDR_W-1:0]         st_err_addr,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  output logic [XLEN/8-1:0]         mem_be,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_conflict,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [ADDR_W-1:0] ent_addr  [DEPTH];
  logic [XLEN-1:0]   ent_wdata [DEPTH];
  logic [NB-1:0]     ent_be    [DEPTH];
  logic [DEPTH-1:0]  ent_valid;

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic [OFS-1:0]    off;
  logic [NB-1:0]     be_base;
  logic [NB-1:0]     fmt_be;
  logic [XLEN-1:0]   data_mask;
  logic [XLEN-1:0]   fmt_wdata;
  logic [ADDR_W-1:0] aligned_addr;
  logic              illegal;
  logic              misaligned;
  logic              req;
  logic              fire;
  logic              err_req;
  logic              drain;
  logic [ADDR_W-1:0] ld_word;

  // Store formatting: build an unshifted mask of the low `size` lanes, then
  // shift both enables and masked data up to the addressed lane so every
  // unused lane stays zero.
  always_comb begin
    off       = st_addr[OFS-1:0];
    be_base   = '0;
    data_mask = '0;
    for (int i = 0; i < NB; i++) begin
      be_base[i]          = (i < (1 << st_type));
      data_mask[8*i +: 8] = {8{be_base[i]}};
    end
    fmt_be       = be_base << off;
    fmt_wdata    = (st_data & data_mask) << {off, 3'b000};
    aligned_addr = {st_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
  end

  // Legality and alignment. SD only exists on a 64-bit datapath; each size
  // must sit on its own natural boundary.
  always_comb begin
    illegal = (st_type == 2'b11) && (XLEN < 64);
    case (st_type)
      2'b01:   misaligned = st_addr[0];
      2'b10:   misaligned = |st_addr[1:0];
      2'b11:   misaligned = |st_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Handshake decode. st_ready depends only on registered occupancy, so a
  // same-cycle drain never opens a slot for a store in that cycle. Because
  // fire needs !full and drain needs !empty, head and tail differ whenever
  // both happen together.
  always_comb begin
    st_ready  = (count != CW'(DEPTH));
    mem_valid = (count != '0);
    empty     = (count == '0);
    req       = st_valid && st_ready;
    fire      = req && !illegal && !misaligned;
    err_req   = req && (illegal || misaligned);
    drain     = mem_valid && mem_ready;
    mem_addr  = ent_addr[head];
    mem_wdata = ent_wdata[head];
    mem_be    = ent_be[head];
  end

  // Word-granular load hazard check against every live entry. Entry
  // addresses are already word aligned, so shifting both sides compares
  // only the word-index bits.
  always_comb begin
    ld_word     = ld_addr >> OFS;
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ((ent_addr[i] >> OFS) == ld_word)) begin
        ld_conflict = 1'b1;
      end
    end
  end

  // FIFO state. Flush wins over any same-cycle enqueue or dequeue; the
  // memory side may still have taken the head that cycle, but the buffer
  // simply forgets everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i]  <= '0;
        ent_wdata[i] <= '0;
        ent_be[i]    <= '0;
      end
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (fire) begin
        ent_addr[tail]  <= aligned_addr;
        ent_wdata[tail] <= fmt_wdata;
        ent_be[tail]    <= fmt_be;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({fire, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Error pulse: raised for one cycle after a rejected request. The address
  // is held afterwards so it can still be read once the pulse has dropped.
  // Flush does not touch this path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_err_valid <= 1'b0;
      st_err_addr  <= '0;
    end else begin
      st_err_valid <= err_req;
      if (err_req) begin
        st_err_addr <= st_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_unit.sv
// tb_store_buffer_unit
//   Drives a 32-bit store buffer with directed and random traffic and
//   compares it every cycle against a queue-based model; a second 64-bit
//   instance covers the SD and upper-lane formatting.
module tb_store_buffer_unit;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        rst_n     = 1'b0;
  logic        st_valid  = 1'b0;
  logic [1:0]  st_type   = 2'b00;
  logic [31:0] st_addr   = '0;
  logic [31:0] st_data   = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] ld_addr   = '0;
  logic        flush     = 1'b0;
  logic        st_ready;
  logic        st_err_valid;
  logic [31:0] st_err_addr;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        ld_conflict;
  logic [2:0]  count;
  logic        empty;

  // 64-bit instance signals
  logic        st_valid_w  = 1'b0;
  logic [1:0]  st_type_w   = 2'b00;
  logic [31:0] st_addr_w   = '0;
  logic [63:0] st_data_w   = '0;
  logic        mem_ready_w = 1'b0;
  logic [31:0] ld_addr_w   = '0;
  logic        flush_w     = 1'b0;
  logic        st_ready_w;
  logic        st_err_valid_w;
  logic [31:0] st_err_addr_w;
  logic        mem_valid_w;
  logic [31:0] mem_addr_w;
  logic [63:0] mem_wdata_w;
  logic [7:0]  mem_be_w;
  logic        ld_conflict_w;
  logic [2:0]  count_w;
  logic        empty_w;

  store_buffer_unit #(.XLEN(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data),
    .st_err_valid(st_err_valid), .st_err_addr(st_err_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .flush(flush), .count(count), .empty(empty)
  );

  store_buffer_unit #(.XLEN(64), .DEPTH(DEPTH), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid_w), .st_ready(st_ready_w), .st_type(st_type_w),
    .st_addr(st_addr_w), .st_data(st_data_w),
    .st_err_valid(st_err_valid_w), .st_err_addr(st_err_addr_w),
    .mem_valid(mem_valid_w), .mem_ready(mem_ready_w), .mem_addr(mem_addr_w),
    .mem_wdata(mem_wdata_w), .mem_be(mem_be_w),
    .ld_addr(ld_addr_w), .ld_conflict(ld_conflict_w),
    .flush(flush_w), .count(count_w), .empty(empty_w)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit checking  = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the buffer is just an ordered list of formatted stores.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  bit          m_err      = 1'b0;
  logic [31:0] m_err_addr = '0;

  function automatic bit model_bad(input logic [1:0] t, input logic [31:0] a);
    int size = 1 << t;
    return (t == 2'b11) || ((a % size) != 0);
  endfunction

  function automatic ent_t model_fmt(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    longint unsigned size = 1 << t;
    longint unsigned ofs  = a % 4;
    longint unsigned mask = (64'd1 << (8 * size)) - 1;
    e.addr  = a - 32'(ofs);
    e.be    = 4'(((64'd1 << size) - 1) << ofs);
    e.wdata = 32'((64'(d) & mask) << (8 * ofs));
    return e;
  endfunction

  // Model update on each rising edge, from the inputs presented that cycle.
  always @(posedge clk) begin
    bit rdy;
    bit drn;
    bit nerr;
    rdy  = mq.size() < DEPTH;
    drn  = (mq.size() != 0) && mem_ready;
    nerr = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_err      = 1'b0;
      m_err_addr = '0;
    end else begin
      if (st_valid && rdy && model_bad(st_type, st_addr)) begin
        nerr       = 1'b1;
        m_err_addr = st_addr;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (drn) void'(mq.pop_front());
        if (st_valid && rdy && !model_bad(st_type, st_addr))
          mq.push_back(model_fmt(st_type, st_addr, st_data));
      end
      m_err = nerr;
    end
  end

  // Compare process: every falling edge, the DUT must match the model.
  always @(negedge clk) begin
    if (checking) begin
      bit conf;
      conf = 1'b0;
      foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) conf = 1'b1;
      check_output("st_ready",     st_ready,     mq.size() < DEPTH);
      check_output("mem_valid",    mem_valid,    mq.size() != 0);
      check_output("count",        count,        64'(mq.size()));
      check_output("empty",        empty,        mq.size() == 0);
      check_output("st_err_valid", st_err_valid, m_err);
      check_output("st_err_addr",  st_err_addr,  m_err_addr);
      check_output("ld_conflict",  ld_conflict,  conf);
      if (mq.size() != 0) begin
        check_output("mem_addr",  mem_addr,  mq[0].addr);
        check_output("mem_wdata", mem_wdata, mq[0].wdata);
        check_output("mem_be",    mem_be,    mq[0].be);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] t, input logic [31:0] a,
                                input logic [31:0] d, input logic mr, input logic fl);
    st_valid  = v;
    st_type   = t;
    st_addr   = a;
    st_data   = d;
    mem_ready = mr;
    flush     = fl;
  endtask

  task automatic apply_stimulus64(input logic [1:0] t, input logic [31:0] a, input logic [63:0] d);
    st_type_w  = t;
    st_addr_w  = a;
    st_data_w  = d;
    st_valid_w = 1'b1;
    step();
    st_valid_w = 1'b0;
  endtask

  task automatic drain64();
    mem_ready_w = 1'b1;
    step();
    mem_ready_w = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step();
    step();
    rst_n    = 1'b1;
    checking = 1'b1;
    check_output("rst st_ready",  st_ready,  1);
    check_output("rst mem_valid", mem_valid, 0);
    check_output("rst count",     count,     0);
    check_output("rst empty",     empty,     1);
    check_output("rst mem_addr",  mem_addr,  0);
    check_output("rst mem_wdata", mem_wdata, 0);
    check_output("rst mem_be",    mem_be,    0);
    check_output("rst err",       st_err_valid, 0);

    // Formatting, one store at a time, visible right after the accepting edge
    apply_stimulus(1, 2'b00, 32'h1003, 32'hAABBCCDD, 0, 0);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    check_output("sb mem_valid", mem_valid, 1);
    check_output("sb mem_addr",  mem_addr,  32'h1000);
    check_output("sb mem_be",    mem_be,    4'b1000);
    check_output("sb mem_wdata", mem_wdata, 32'hDD000000);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    apply_stimulus(1, 2'b01, 32'h1002, 32'hAABBCCDD, 0, 0);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    check_output("sh mem_be",    mem_be,    4'b1100);
    check_output("sh mem_wdata", mem_wdata, 32'hCCDD0000);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    apply_stimulus(1, 2'b10, 32'h1004, 32'hAABBCCDD, 0, 0);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    check_output("sw mem_addr",  mem_addr,  32'h1004);
    check_output("sw mem_be",    mem_be,    4'b1111);
    check_output("sw mem_wdata", mem_wdata, 32'hAABBCCDD);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;

    // Misaligned SW and illegal SD on the 32-bit datapath
    apply_stimulus(1, 2'b10, 32'h1006, 32'h12345678, 0, 0);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    check_output("misal count",    count,        0);
    check_output("misal err",      st_err_valid, 1);
    check_output("misal err_addr", st_err_addr,  32'h1006);
    step();
    check_output("misal err drop", st_err_valid, 0);
    apply_stimulus(1, 2'b11, 32'h1008, 32'h12345678, 0, 0);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    check_output("sd32 count",    count,        0);
    check_output("sd32 err",      st_err_valid, 1);
    check_output("sd32 err_addr", st_err_addr,  32'h1008);
    step();
    check_output("sd32 err drop", st_err_valid, 0);

    // 64-bit datapath formatting
    apply_stimulus64(2'b11, 32'h2000, 64'h1122334455667788);
    check_output("sd64 mem_be",    mem_be_w,    8'hFF);
    check_output("sd64 mem_wdata", mem_wdata_w, 64'h1122334455667788);
    check_output("sd64 mem_addr",  mem_addr_w,  32'h2000);
    drain64();
    apply_stimulus64(2'b10, 32'h2004, 64'h1122334455667788);
    check_output("sw64 mem_be",    mem_be_w,    8'hF0);
    check_output("sw64 mem_wdata", mem_wdata_w, 64'h5566778800000000);
    check_output("sw64 mem_addr",  mem_addr_w,  32'h2000);
    drain64();
    apply_stimulus64(2'b00, 32'h2005, 64'h1122334455667788);
    check_output("sb64 mem_be",    mem_be_w,    8'h20);
    check_output("sb64 mem_wdata", mem_wdata_w, 64'h0000880000000000);
    drain64();
    apply_stimulus64(2'b11, 32'h2004, 64'h1);
    check_output("sd64 misal err",   st_err_valid_w, 1);
    check_output("sd64 misal count", count_w,        0);

    // Full / backpressure: five stores offered, four taken
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, 2'b10, 32'h3000 + 32'(4 * k), $urandom, 0, 0);
      step();
    end
    check_output("full count",    count,    4);
    check_output("full st_ready", st_ready, 0);
    check_output("full head",     mem_addr, 32'h3000);
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    step();
    check_output("full head hold", mem_addr, 32'h3000);
    mem_ready = 1'b1;
    step();
    check_output("drain1 count",    count,    3);
    check_output("drain1 st_ready", st_ready, 1);
    check_output("drain1 head",     mem_addr, 32'h3004);
    step(); step(); step();
    check_output("drained empty", empty, 1);
    mem_ready = 1'b0;

    // Simultaneous enqueue/dequeue keeps count at 2 across pointer wrap
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1, 2'b10, 32'h5000 + 32'(4 * k), $urandom, 0, 0);
      step();
    end
    for (int k = 2; k < 12; k++) begin
      apply_stimulus(1, 2'b10, 32'h5000 + 32'(4 * k), $urandom, 1, 0);
      step();
      check_output("simul count", count, 2);
    end
    apply_stimulus(0, 2'b00, 0, 0, 1, 0);
    step(); step();
    check_output("simul drained", empty, 1);

    // Flush with three entries and a concurrent fire
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 2'b00, 32'h6000 + 32'(k), $urandom, 0, 0);
      step();
    end
    check_output("preflush count", count, 3);
    apply_stimulus(1, 2'b10, 32'h6010, $urandom, 0, 1);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    check_output("flush count",     count,     0);
    check_output("flush mem_valid", mem_valid, 0);

    // Load conflict
    apply_stimulus(1, 2'b00, 32'h1003, 32'hFF, 0, 0);
    step();
    apply_stimulus(0, 2'b00, 0, 0, 0, 0);
    ld_addr = 32'h1000; #1;
    check_output("conf same word", ld_conflict, 1);
    ld_addr = 32'h1004; #1;
    check_output("conf next word", ld_conflict, 0);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    ld_addr = 32'h1000; #1;
    check_output("conf drained", ld_conflict, 0);

    // Random traffic in a small address window so conflicts and wraps occur
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus(($urandom % 3) != 0, 2'($urandom), 32'h4000 + ($urandom % 64),
                     $urandom, 1'($urandom), ($urandom % 40) == 0);
      ld_addr = 32'h4000 + ($urandom % 64);
      rst_n   = ($urandom % 400) != 0;
      step();
    end
    rst_n = 1'b1;
    apply_stimulus(0, 2'b00, 0, 0, 1, 0);
    for (int c = 0; c < 8; c++) step();

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
